// File: rtl/parity_tx_pkg.sv
// Shared definitions for the parity-framed nibble serial link.
// Holds the state encoding and frame geometry so a matching receiver
// can decode the same frame without redefining them.
package parity_tx_pkg;

    localparam int FRAME_BITS = 7;
    localparam int DATA_BITS  = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    // 1 when the nibble holds an odd number of ones.
    function automatic logic nibble_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/parity_frame_tx_bit_timer.sv
// Bit-period timer: counts clock cycles inside one serial bit and flags
// the last cycle (tick) and the cycle before it (pre_tick).
module bit_timer #(
    parameter  int CLKS_PER_BIT = 4,
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_en,
    output logic o_tick,
    output logic o_pre_tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] PRE  = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] r_count;

    // Count cycles within the current bit, wrapping to 0 on its last cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_count <= '0;
        end else if (i_en) begin
            if (r_count == LAST) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign o_tick = (r_count == LAST);
    // With one cycle per bit there is no "cycle before the last one".
    assign o_pre_tick = (CLKS_PER_BIT > 1) && (r_count == PRE);

endmodule

// File: rtl/parity_frame_tx.sv
// Serial transmitter for one nibble per frame:
// start(0), d0..d3 LSB first, parity (XOR of the nibble), stop(1).
// Handshake: a frame is accepted on a rising edge where load=1 and
// ready=1; ready stays low until the cycle after the last stop-bit cycle,
// and load is ignored while ready is low (no queuing).
module parity_frame_tx
    import parity_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      data_in,
    input  logic            load,
    output logic            ready,
    output logic            tx_out,
    output logic            parity_out,
    output logic            done,
    output tx_state_e       dbg_state
);

    tx_state_e       r_state;
    logic [3:0]      r_shift;
    logic [1:0]      r_bit_idx;
    logic            r_tx;
    logic            r_ready;
    logic            r_parity;
    logic            r_done;

    logic            w_accept;
    logic            w_tick;
    logic            w_pre_tick;
    logic            w_timer_en;

    assign w_accept   = load && r_ready;
    assign w_timer_en = (r_state != IDLE);

    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_clear    (w_accept),
        .i_en       (w_timer_en),
        .o_tick     (w_tick),
        .o_pre_tick (w_pre_tick)
    );

    // Frame sequencer: every output is registered and carries the value
    // for the bit that the new state is about to send.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_tx      <= 1'b1;
            r_ready   <= 1'b1;
            r_parity  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state   <= START;
                        r_tx      <= 1'b0;
                        r_ready   <= 1'b0;
                        r_shift   <= data_in;
                        r_parity  <= nibble_parity(data_in);
                        r_bit_idx <= '0;
                    end
                end
                START: begin
                    if (w_tick) begin
                        r_state <= DATA;
                        r_tx    <= r_shift[0];
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        if (r_bit_idx == 2'd3) begin
                            r_state <= PARITY;
                            r_tx    <= r_parity;
                        end else begin
                            r_tx <= r_shift[1];
                        end
                        r_shift   <= {1'b0, r_shift[3:1]};
                        r_bit_idx <= r_bit_idx + 2'd1;
                    end
                end
                PARITY: begin
                    if (w_tick) begin
                        r_state <= STOP;
                        r_tx    <= 1'b1;
                        // A one-cycle stop bit is its own last cycle.
                        r_done  <= (CLKS_PER_BIT == 1);
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        r_state <= IDLE;
                        r_ready <= 1'b1;
                    end else begin
                        // Raise done so it lines up with the final stop cycle.
                        r_done <= w_pre_tick;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign ready      = r_ready;
    assign tx_out     = r_tx;
    assign parity_out = r_parity;
    assign done       = r_done;
    assign dbg_state  = r_state;

endmodule

// File: doc/parity_frame_tx.md
PARITY_FRAME_TX -- requirements
Module: parity_frame_tx

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, 4, clock cycles per serial bit period (legal range 1..255).
REQ-002 SHALL have port: clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  reset is synchronous and active-high.
REQ-004 SHALL have port: data_in  input  4  nibble to transmit (one student-ID digit).
REQ-005 SHALL have port: load  input  1  request to send data_in; accepted only when ready=1.
REQ-006 SHALL have port: ready  output  1  high when idle and able to accept load.
REQ-007 SHALL have port: tx_out  output  1  serial line; idle high.
REQ-008 SHALL have port: parity_out  output  1  parity bit of the frame in flight, held until next accept.
REQ-009 SHALL have port: done  output  1  one-cycle pulse at end of stop bit.

Function
REQ-010 SHALL frame each nibble as: start (0), data_in[0], [1], [2], [3], parity, stop (1); 7 bits total, LSB first.
REQ-011 SHALL compute parity as data_in[3]^data_in[2]^data_in[1]^data_in[0] (1 = odd count of ones), same convention as the ALU parity check.
REQ-012 SHALL capture data_in and parity into internal registers on the accepting edge (load=1 and ready=1); later data_in changes SHALL not affect the frame.
REQ-013 SHALL use states IDLE, START, DATA, PARITY, STOP; IDLE->START on accept; START->DATA, DATA->PARITY after 4th data bit, PARITY->STOP, STOP->IDLE, each after CLKS_PER_BIT cycles.
REQ-014 SHALL drive tx_out low starting the cycle after the accepting edge (latency 1) and hold each bit exactly CLKS_PER_BIT cycles.
REQ-015 SHALL complete a frame in 7*CLKS_PER_BIT cycles from first start-bit cycle to last stop-bit cycle.
REQ-016 SHALL hold ready=0 from the cycle after acceptance through the last stop-bit cycle; ready=1 in IDLE.
REQ-017 SHALL assert done for exactly the last stop-bit cycle; ready returns to 1 the following cycle.
REQ-018 SHALL ignore load while ready=0 (no queuing, no frame corruption).
REQ-019 SHALL permit back-to-back frames: load held high accepts a new nibble the first cycle ready=1, giving one idle-high cycle between frames.
REQ-020 SHALL use a bit-period counter of width ceil(log2(CLKS_PER_BIT)) min 1, wrapping to 0 at CLKS_PER_BIT-1; data-bit index 2 bits, wrapping after bit 3.

Reset
REQ-021 SHALL, on reset=1 at a clock edge, set state=IDLE, tx_out=1, ready=1, done=0, parity_out=0, counters=0.
REQ-022 SHALL abort any frame in progress on reset, with tx_out=1 from the following cycle; no done pulse for the aborted frame.
REQ-023 SHALL give reset priority over load in the same cycle (load not accepted).

Structure
REQ-024 SHALL place the state encoding (IDLE..STOP) and constants FRAME_BITS=7, DATA_BITS=4 in shared package parity_tx_pkg, for reuse by a future matching receiver.
REQ-025 SHALL implement bit timing in one sub-module, bit_timer (counter + tick output), instantiated once; FSM and shift register stay in parity_frame_tx.

Verification
REQ-026 SHALL cover: CLKS_PER_BIT=4, load data_in=4'b1011 -> tx_out sequence 0,1,1,0,1,1,1 each 4 cycles, parity_out=1, done at cycle 28 after accept+1.
REQ-027 SHALL cover: data_in=4'b0000 and 4'b1111 -> parity bit 0 in both; data_in=4'b0001 -> parity bit 1.
REQ-028 SHALL cover: load pulsed with 4'b0110 mid-frame of 4'b1011 -> ignored; transmitted frame unchanged, ready stays 0.
REQ-029 SHALL cover: load held high with 4'b0011 then 4'b1000 -> two complete frames separated by exactly one idle-high cycle, two done pulses.
REQ-030 SHALL cover: reset asserted during DATA bit 2 -> next cycle tx_out=1, ready=1, no done; a subsequent load 4'b0101 yields a correct frame with parity 0.
REQ-031 SHALL cover: CLKS_PER_BIT=1, data_in=4'b0111 -> 7-cycle frame 0,1,1,1,0,1,1, done on 7th cycle.
